// File: rtl/postmortem_capture_ring.sv
// Multi-channel post-mortem recorder: decimated ring capture that freezes a
// programmable number of samples after an interlock edge, read oldest-first.
module postmortem_capture_ring #(
   parameter int CH_NUM = 10,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4096,
   parameter int AW     = $clog2(DEPTH),
   parameter int DIV_W  = 16,
   parameter int CW     = $clog2(CH_NUM)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [CH_NUM*DATA_W-1:0] i_data,
   input  logic [DIV_W-1:0]         i_div,
   input  logic [AW-1:0]            i_post_cnt,
   input  logic                     i_trig,
   input  logic                     i_arm,
   input  logic                     i_rd_en,
   input  logic [CW-1:0]            i_rd_ch,
   input  logic [AW-1:0]            i_rd_idx,
   output logic [DATA_W-1:0]        o_rd_data,
   output logic                     o_rd_valid,
   output logic                     o_frozen,
   output logic [1:0]               o_state,
   output logic [AW:0]              o_fill,
   output logic [AW-1:0]            o_trig_addr,
   output logic [AW-1:0]            o_wr_addr
);

   typedef enum logic [1:0] {S_ARMED = 2'd0, S_POST = 2'd1, S_FROZEN = 2'd2} state_t;

   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_F = (AW + 1)'(DEPTH);
   localparam logic [AW+1:0] DEPTH_X = (AW + 2)'(DEPTH);
   localparam logic [CW:0]   CH_LIM  = (CW + 1)'(CH_NUM);

   logic [CH_NUM*DATA_W-1:0] r_mem [DEPTH];

   state_t               r_state;
   logic [DIV_W-1:0]     r_cnt;
   logic [AW-1:0]        r_wr_addr;
   logic [AW:0]          r_fill;
   logic [AW-1:0]        r_post_left;
   logic [AW-1:0]        r_trig_addr;
   logic                 r_trig_d;
   logic                 r_frozen;
   logic                 r_rd_v1;
   logic [AW-1:0]        r_rd_phys;
   logic [CW-1:0]        r_rd_ch;
   logic                 r_rd_oor;
   logic                 r_rd_valid;
   logic [DATA_W-1:0]    r_rd_data;

   logic                 w_tick;
   logic                 w_edge;
   logic [AW-1:0]        w_wr_next;
   logic [AW-1:0]        w_post_clamp;
   logic [AW+1:0]        w_base;
   logic [AW+1:0]        w_sum;
   logic [AW-1:0]        w_phys;
   logic                 w_oor;
   logic [DATA_W-1:0]    w_ch_data;

   assign w_tick       = (r_state != S_FROZEN) && (r_cnt >= i_div);
   assign w_edge       = i_trig & ~r_trig_d;
   assign w_wr_next    = (r_wr_addr == LAST) ? {AW{1'b0}} : r_wr_addr + AW'(1);
   assign w_post_clamp = (i_post_cnt > LAST) ? LAST : i_post_cnt;

   // Decimation counter; parked at zero while frozen.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= {DIV_W{1'b0}};
      end else if (r_state == S_FROZEN || w_tick) begin
         r_cnt <= {DIV_W{1'b0}};
      end else begin
         r_cnt <= r_cnt + DIV_W'(1);
      end
   end

   // Ring write pointer and saturating fill level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_addr <= {AW{1'b0}};
         r_fill    <= {(AW + 1){1'b0}};
      end else if (w_tick) begin
         r_wr_addr <= w_wr_next;
         if (r_fill != DEPTH_F) begin
            r_fill <= r_fill + (AW + 1)'(1);
         end
      end else if (r_state == S_FROZEN && i_arm) begin
         r_fill <= {(AW + 1){1'b0}};
      end
   end

   // Sample RAM write port; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (w_tick) begin
         r_mem[r_wr_addr] <= i_data;
      end
   end

   // Capture FSM: a tick coinciding with the edge is still pre-trigger.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_ARMED;
         r_post_left <= {AW{1'b0}};
         r_trig_addr <= {AW{1'b0}};
         r_trig_d    <= 1'b0;
         r_frozen    <= 1'b0;
      end else begin
         r_trig_d <= i_trig;
         case (r_state)
            S_ARMED: begin
               if (w_edge) begin
                  r_trig_addr <= w_tick ? w_wr_next : r_wr_addr;
                  r_post_left <= w_post_clamp;
                  if (w_post_clamp == {AW{1'b0}}) begin
                     r_state  <= S_FROZEN;
                     r_frozen <= 1'b1;
                  end else begin
                     r_state <= S_POST;
                  end
               end
            end
            S_POST: begin
               if (w_tick) begin
                  r_post_left <= r_post_left - AW'(1);
                  if (r_post_left == AW'(1)) begin
                     r_state  <= S_FROZEN;
                     r_frozen <= 1'b1;
                  end
               end
            end
            S_FROZEN: begin
               if (i_arm) begin
                  r_state  <= S_ARMED;
                  r_frozen <= 1'b0;
               end
            end
            default: begin
               r_state  <= S_ARMED;
               r_frozen <= 1'b0;
            end
         endcase
      end
   end

   // Logical-to-physical mapping; DEPTH need not be a power of two.
   always_comb begin
      w_base = (AW + 2)'(r_wr_addr) + DEPTH_X - (AW + 2)'(r_fill);
      if (w_base >= DEPTH_X) begin
         w_base = w_base - DEPTH_X;
      end else begin
         w_base = w_base;
      end
      w_sum = w_base + (AW + 2)'(i_rd_idx);
      if (w_sum >= DEPTH_X) begin
         w_sum = w_sum - DEPTH_X;
      end else begin
         w_sum = w_sum;
      end
      w_phys = (w_sum >= DEPTH_X) ? AW'(w_sum - DEPTH_X) : AW'(w_sum);
      w_oor  = ({1'b0, i_rd_idx} >= r_fill) || ({1'b0, i_rd_ch} >= CH_LIM);
   end

   // Read stage 1: registered address, channel and range flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_v1   <= 1'b0;
         r_rd_phys <= {AW{1'b0}};
         r_rd_ch   <= {CW{1'b0}};
         r_rd_oor  <= 1'b0;
      end else begin
         r_rd_v1 <= i_rd_en;
         if (i_rd_en) begin
            r_rd_phys <= w_phys;
            r_rd_ch   <= i_rd_ch;
            r_rd_oor  <= w_oor;
         end
      end
   end

   // Channel select from the addressed RAM word.
   always_comb begin
      w_ch_data = {DATA_W{1'b0}};
      for (int k = 0; k < CH_NUM; k++) begin
         w_ch_data = w_ch_data |
                     ({DATA_W{r_rd_ch == CW'(k)}} & r_mem[r_rd_phys][k*DATA_W +: DATA_W]);
      end
   end

   // Read stage 2: registered data that holds between pulses.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= {DATA_W{1'b0}};
      end else begin
         r_rd_valid <= r_rd_v1;
         if (r_rd_v1) begin
            r_rd_data <= r_rd_oor ? {DATA_W{1'b0}} : w_ch_data;
         end
      end
   end

   assign o_rd_data   = r_rd_data;
   assign o_rd_valid  = r_rd_valid;
   assign o_frozen    = r_frozen;
   assign o_state     = r_state;
   assign o_fill      = r_fill;
   assign o_trig_addr = r_trig_addr;
   assign o_wr_addr   = r_wr_addr;

endmodule

// File: tb/tb_postmortem_capture_ring.sv
// Directed bench: DEPTH=16 recorder plus a DEPTH=12 instance sharing stimulus
// to exercise post-count clamping and non-power-of-two wrap.
module tb_postmortem_capture_ring;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [47:0] i_data;
   logic [15:0] i_div;
   logic [3:0]  i_post_cnt;
   logic        i_trig;
   logic        i_arm;
   logic        i_rd_en;
   logic [1:0]  i_rd_ch;
   logic [3:0]  i_rd_idx;

   logic [15:0] o_rd_data,   b_rd_data;
   logic        o_rd_valid,  b_rd_valid;
   logic        o_frozen,    b_frozen;
   logic [1:0]  o_state,     b_state;
   logic [4:0]  o_fill,      b_fill;
   logic [3:0]  o_trig_addr, b_trig_addr;
   logic [3:0]  o_wr_addr,   b_wr_addr;

   int n_cmp = 0;
   int n_err = 0;

   always #5 i_clk = ~i_clk;

   postmortem_capture_ring #(.CH_NUM(3), .DATA_W(16), .DEPTH(16), .DIV_W(16)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_div(i_div),
      .i_post_cnt(i_post_cnt), .i_trig(i_trig), .i_arm(i_arm), .i_rd_en(i_rd_en),
      .i_rd_ch(i_rd_ch), .i_rd_idx(i_rd_idx), .o_rd_data(o_rd_data),
      .o_rd_valid(o_rd_valid), .o_frozen(o_frozen), .o_state(o_state),
      .o_fill(o_fill), .o_trig_addr(o_trig_addr), .o_wr_addr(o_wr_addr));

   postmortem_capture_ring #(.CH_NUM(3), .DATA_W(16), .DEPTH(12), .DIV_W(16)) dut12 (
      .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_div(i_div),
      .i_post_cnt(i_post_cnt), .i_trig(i_trig), .i_arm(i_arm), .i_rd_en(i_rd_en),
      .i_rd_ch(i_rd_ch), .i_rd_idx(i_rd_idx), .o_rd_data(b_rd_data),
      .o_rd_valid(b_rd_valid), .o_frozen(b_frozen), .o_state(b_state),
      .o_fill(b_fill), .o_trig_addr(b_trig_addr), .o_wr_addr(b_wr_addr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tk();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [47:0] dat(input int s, input int off);
      return {16'(200 + off + s), 16'(100 + off + s), 16'(off + s)};
   endfunction

   task automatic rd(input int ch, input int idx);
      i_rd_en  = 1'b1;
      i_rd_ch  = 2'(ch);
      i_rd_idx = 4'(idx);
      tk();
      i_rd_en = 1'b0;
      chk("rd_latency_gap", 32'(o_rd_valid), 32'd0);
      tk();
      chk("rd_valid", 32'(o_rd_valid), 32'd1);
   endtask

   initial begin
      i_rst = 1'b0; i_data = 48'd0; i_div = 16'd0; i_post_cnt = 4'd4;
      i_trig = 1'b0; i_arm = 1'b0; i_rd_en = 1'b0; i_rd_ch = 2'd0; i_rd_idx = 4'd0;
      #2 i_rst = 1'b1;
      tk(); tk();
      chk("rst_state", 32'(o_state), 32'd0);
      chk("rst_wr", 32'(o_wr_addr), 32'd0);
      chk("rst_fill", 32'(o_fill), 32'd0);
      chk("rst_frozen", 32'(o_frozen), 32'd0);
      chk("rst_trig", 32'(o_trig_addr), 32'd0);
      chk("rst_valid", 32'(o_rd_valid), 32'd0);
      chk("rst_data", 32'(o_rd_data), 32'd0);

      // Capture 1: 34 samples, edge alongside sample 29, four post samples.
      i_rst = 1'b0;
      for (int s = 0; s < 34; s++) begin
         i_data = dat(s, 0);
         i_trig = (s >= 29);
         tk();
         if (s == 29) begin
            chk("c1_post_entry", 32'(o_state), 32'd1);
            chk("c1_trig_addr_early", 32'(o_trig_addr), 32'd14);
         end
      end
      chk("c1_state", 32'(o_state), 32'd2);
      chk("c1_frozen", 32'(o_frozen), 32'd1);
      chk("c1_fill", 32'(o_fill), 32'd16);
      chk("c1_wr", 32'(o_wr_addr), 32'd2);
      chk("c1_trig_addr", 32'(o_trig_addr), 32'd14);
      for (int s = 34; s < 40; s++) begin
         i_data = dat(s, 0);
         tk();
      end
      chk("c1_hold_wr", 32'(o_wr_addr), 32'd2);
      chk("c1_hold_fill", 32'(o_fill), 32'd16);
      rd(0, 0);  chk("c1_idx0_ch0", 32'(o_rd_data), 32'd18);
      rd(2, 15); chk("c1_idx15_ch2", 32'(o_rd_data), 32'd233);
      rd(1, 5);  chk("c1_idx5_ch1", 32'(o_rd_data), 32'd123);
      rd(3, 0);  chk("c1_bad_ch", 32'(o_rd_data), 32'd0);

      // Sixteen back-to-back reads, results two clocks behind requests.
      for (int c = 0; c <= 16; c++) begin
         i_rd_en  = (c < 16);
         i_rd_ch  = 2'd1;
         i_rd_idx = 4'(c);
         tk();
         if (c == 0) begin
            chk("b2b_first_gap", 32'(o_rd_valid), 32'd0);
         end else begin
            chk("b2b_valid", 32'(o_rd_valid), 32'd1);
            chk("b2b_data", 32'(o_rd_data), 32'(118 + c - 1));
         end
      end
      i_rd_en = 1'b0;
      tk();
      chk("b2b_end", 32'(o_rd_valid), 32'd0);

      // Re-arm with a simultaneous trigger edge; then post count of zero.
      i_trig = 1'b0;
      tk();
      i_arm = 1'b1; i_trig = 1'b1;
      tk();
      chk("arm_state", 32'(o_state), 32'd0);
      chk("arm_fill", 32'(o_fill), 32'd0);
      chk("arm_wr_kept", 32'(o_wr_addr), 32'd2);
      chk("arm_frozen", 32'(o_frozen), 32'd0);
      i_arm = 1'b0; i_trig = 1'b0; i_post_cnt = 4'd0;
      for (int t = 0; t < 5; t++) begin
         i_data = dat(t, 200);
         i_trig = (t == 4);
         tk();
         if (t == 0) begin
            chk("arm_trig_ignored", 32'(o_state), 32'd0);
            chk("arm_first_fill", 32'(o_fill), 32'd1);
         end
      end
      chk("p0_state", 32'(o_state), 32'd2);
      chk("p0_frozen", 32'(o_frozen), 32'd1);
      chk("p0_fill", 32'(o_fill), 32'd5);
      chk("p0_wr", 32'(o_wr_addr), 32'd7);
      chk("p0_trig_addr", 32'(o_trig_addr), 32'd7);
      rd(0, 5);  chk("p0_idx5", 32'(o_rd_data), 32'd0);
      rd(1, 15); chk("p0_idx15", 32'(o_rd_data), 32'd0);
      rd(0, 0);  chk("p0_idx0", 32'(o_rd_data), 32'd200);
      rd(2, 4);  chk("p0_idx4_ch2", 32'(o_rd_data), 32'd404);

      // Reset in the middle of POST with a read in flight.
      i_trig = 1'b0; i_arm = 1'b1;
      tk();
      i_arm = 1'b0;
      chk("c3_armed", 32'(o_state), 32'd0);
      i_post_cnt = 4'd15;
      for (int t = 0; t < 4; t++) begin
         i_data = dat(t, 500);
         i_trig = (t >= 2);
         tk();
      end
      chk("c3_post", 32'(o_state), 32'd1);
      chk("c3_wr", 32'(o_wr_addr), 32'd11);
      i_rd_en = 1'b1; i_rd_ch = 2'd0; i_rd_idx = 4'd0;
      tk();
      i_rd_en = 1'b0;
      #1 i_rst = 1'b1;
      #1;
      chk("mid_rst_state", 32'(o_state), 32'd0);
      chk("mid_rst_wr", 32'(o_wr_addr), 32'd0);
      chk("mid_rst_fill", 32'(o_fill), 32'd0);
      chk("mid_rst_frozen", 32'(o_frozen), 32'd0);
      chk("mid_rst_trig", 32'(o_trig_addr), 32'd0);
      chk("mid_rst_valid", 32'(o_rd_valid), 32'd0);
      chk("mid_rst_data", 32'(o_rd_data), 32'd0);
      tk();
      chk("mid_rst_valid_hold", 32'(o_rd_valid), 32'd0);

      // Decimated capture, i_div=3: one write every fourth clock.
      i_div = 16'd3; i_trig = 1'b0; i_data = dat(0, 300); i_rst = 1'b0;
      rd(0, 0); chk("post_rst_read", 32'(o_rd_data), 32'd0);
      tk();
      chk("div_gap", 32'(o_wr_addr), 32'd0);
      tk();
      chk("div_first", 32'(o_wr_addr), 32'd1);
      for (int j = 1; j < 20; j++) begin
         for (int c = 0; c < 4; c++) begin
            i_data = dat(j, 300);
            i_trig = (j >= 5);
            i_arm  = (j == 10 && c == 0);
            tk();
         end
         if (j == 4) begin
            chk("div_fill5", 32'(o_fill), 32'd5);
            chk("div_wr5", 32'(o_wr_addr), 32'd5);
         end
         if (j == 10) chk("arm_in_post", 32'(o_state), 32'd1);
         if (j == 15) begin
            chk("d12_frozen_state", 32'(b_state), 32'd2);
            chk("d12_frozen_wr", 32'(b_wr_addr), 32'd4);
         end
         if (j == 18) chk("div_still_post", 32'(o_state), 32'd1);
      end
      i_arm = 1'b0;
      chk("div_state", 32'(o_state), 32'd2);
      chk("div_frozen", 32'(o_frozen), 32'd1);
      chk("div_fill", 32'(o_fill), 32'd16);
      chk("div_wr", 32'(o_wr_addr), 32'd4);
      chk("div_trig_addr", 32'(o_trig_addr), 32'd5);
      chk("d12_state", 32'(b_state), 32'd2);
      chk("d12_frozen", 32'(b_frozen), 32'd1);
      chk("d12_fill", 32'(b_fill), 32'd12);
      chk("d12_wr", 32'(b_wr_addr), 32'd4);
      chk("d12_trig_addr", 32'(b_trig_addr), 32'd5);
      rd(0, 0);
      chk("div_idx0", 32'(o_rd_data), 32'd304);
      chk("d12_idx0", 32'(b_rd_data), 32'd304);
      chk("d12_valid", 32'(b_rd_valid), 32'd1);
      rd(1, 15);
      chk("div_idx15_ch1", 32'(o_rd_data), 32'd419);
      chk("d12_idx15_oor", 32'(b_rd_data), 32'd0);
      rd(2, 11);
      chk("d12_idx11_ch2", 32'(b_rd_data), 32'd515);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
